collision_map_arbiter: RTL
==========================

// Module: collision_map_arbiter
// PURPOSE
//  Shares the single-port 960x500 collision-map block RAM (1-bit "block" per pixel) between NUM_REQ requesters:
//  player movement, enemy walkers, fireball.
//  Arbitrates one lookup per cycle, computes the linear address X + Y*MAP_W and pipelines it through the RAM latency.
//  Returns a one-hot tagged response to the requester that issued the lookup.
//  Sits between the game_calc entity blocks and the collision blk_mem_gen instance.
// PARAMETERS
//  NUM_REQ  4    number of requesters (2..8); requester 0 is the player
//  MAP_W    960  map width in pixels; address = X + Y*MAP_W
//  MAP_H    500  map height in pixels
//  RAM_LAT  1    RAM read latency in cycles, mem_addr -> mem_dout (1..3)
// PORTS
//  sys_clk    in   1           system clock, all logic on rising edge
//  RST_N      in   1           synchronous active-low reset
//  req        in   NUM_REQ     per-requester lookup request, level
//  req_x      in   10*NUM_REQ  X coords; requester i at [10*i+9:10*i]
//  req_y      in   10*NUM_REQ  Y coords, same packing
//  gnt        out  NUM_REQ     one-hot pulse: request captured this cycle
//  rsp_valid  out  NUM_REQ     one-hot pulse: rsp_block valid for that requester
//  rsp_block  out  1           collision result (1 = solid)
//  mem_en     out  1           RAM read enable
//  mem_addr   out  20          RAM address
//  mem_dout   in   1           RAM read data
// BEHAVIOUR
//  - Eligible[i] = req[i] & ~pending[i]. Max one outstanding lookup per requester.
//  - Arbitration is round-robin.
//    - The pointer starts at 0.
//    - Search starts at the pointer; the first eligible index wins.
//    - After a grant to i, the pointer moves to (i+1) mod NUM_REQ.
//    - With no eligible requester, the pointer holds.
//  - Cycle T: req/coords sampled.
//    - Cycle T+1: gnt[i]=1, mem_addr/mem_en registered, pending[i] set.
//    - mem_dout sampled at T+1+RAM_LAT.
//    - Cycle T+2+RAM_LAT: rsp_valid[i]=1, rsp_block registered, pending[i] cleared.
//  - Latency req->rsp_valid = RAM_LAT+2. Throughput is one lookup per cycle across requesters.
//  - The requester holds coords stable until its gnt pulse. It may keep req high to issue the next lookup.
//  - A requester is eligible again in its rsp_valid cycle, so its earliest next gnt is the following cycle.
//  - Address math: zero-extend X and Y to 20 bits, then Y*MAP_W + X, truncated to 20 bits (max 479999 fits).
//  - Out of bounds: X >= MAP_W or Y >= MAP_H.
//    - The lookup is still granted; mem_en=0 and mem_addr=0 for that slot.
//    - The response arrives at the normal latency with rsp_block=1 (off-map is solid).
//  - In-flight tracking is a RAM_LAT+1 deep shift register of {valid, id, oob}. Responses never reorder.
//  - When req drops while pending, the response is still delivered; pending clears normally.
//  - Idle outputs: gnt=0, rsp_valid=0, mem_en=0; rsp_block and mem_addr hold their last values.
//  - Reset (RST_N=0 at a clock edge):
//    - gnt, rsp_valid, rsp_block, mem_en, mem_addr, pending and pointer all go to 0.
//    - The in-flight pipe is flushed. Lookups in flight are dropped with no rsp_valid.
//    - Reset mid-operation behaves the same.
//  - Only one arbitration per cycle. Simultaneous eligible requests are resolved solely by the pointer (or macro below).
// CONFIGURATION
//  COLL_ARB_PLAYER_PRIO_EN defined:
//    - Requester 0 wins whenever eligible, regardless of the pointer.
//    - The others are round-robin among themselves.
//    - Grants to 0 do not move the pointer.
//  Not defined: pure round-robin over all NUM_REQ requesters, as above.
// TESTING (NUM_REQ=4, RAM_LAT=1, RAM model returns addr[0])
//  1. req[0]=1, X=220, Y=360 at T -> gnt=0001 at T+1, mem_addr=345820, mem_en=1.
//     rsp_valid=0001 at T+3, rsp_block=0.
//  2. req=1111 held, all coords (1,0) -> gnt order 0001,0010,0100,1000,0001...
//     One gnt every cycle; each rsp_valid 2 cycles after its gnt; rsp_block=1.
//  3. req[2]=1, X=960, Y=10 -> gnt=0100; mem_en stays 0; rsp_valid=0100 with rsp_block=1 two cycles later.
//     Same result for X=5, Y=500.
//  4. req=1111 for 3 cycles, then RST_N=0 for 1 cycle -> no rsp_valid after the reset edge.
//     Pointer=0, so the first gnt after reset is 0001.
//  5. req[0] and req[2] held high, no macro -> grants alternate 0001/0100.
//     With COLL_ARB_PLAYER_PRIO_EN -> 0001 every cycle req[0] is eligible (every 3rd cycle).
//     req[2] is granted in the gaps.
//  6. req[1] pulsed for exactly its gnt cycle, then 0 -> single rsp_valid=0010; no second gnt.

Source files
------------

// File: rtl/collision_map_arbiter_if.sv
// Requester and RAM-side signal bundle for collision_map_arbiter.
// master: entity blocks plus the collision RAM; slave: the arbiter.
interface collision_map_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [10*NUM_REQ-1:0] req_x;
  logic [10*NUM_REQ-1:0] req_y;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic                  rsp_block;
  logic                  mem_en;
  logic [19:0]           mem_addr;
  logic                  mem_dout;

  modport master (
    output req, req_x, req_y, mem_dout,
    input  gnt, rsp_valid, rsp_block, mem_en, mem_addr
  );

  modport slave (
    input  req, req_x, req_y, mem_dout,
    output gnt, rsp_valid, rsp_block, mem_en, mem_addr
  );
endinterface

// File: rtl/collision_map_arbiter.sv
// Round-robin arbiter sharing the single-port collision-map RAM between requesters.
// Optional macro COLL_ARB_PLAYER_PRIO_EN gives requester 0 (player) absolute priority.
module collision_map_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAP_W   = 960,
  parameter int MAP_H   = 500,
  parameter int RAM_LAT = 1
) (
  input logic                    sys_clk,
  input logic                    RST_N,
  collision_map_arbiter_if.slave bus
);
  localparam int          IDW     = $clog2(NUM_REQ);
  localparam logic [19:0] W_MAP_W = 20'(MAP_W);
`ifdef COLL_ARB_PLAYER_PRIO_EN
  localparam bit PLAYER_PRIO = 1'b1;
`else
  localparam bit PLAYER_PRIO = 1'b0;
`endif

  logic [NUM_REQ-1:0]          r_gnt;
  logic [NUM_REQ-1:0]          r_rsp_valid;
  logic                        r_rsp_block;
  logic                        r_mem_en;
  logic [19:0]                 r_mem_addr;
  logic [NUM_REQ-1:0]          r_pending;
  logic [IDW-1:0]              r_ptr;
  // in-flight pipe: stage RAM_LAT lines up with mem_dout for that slot
  logic [RAM_LAT:0]            r_pv;
  logic [RAM_LAT:0][IDW-1:0]   r_pid;
  logic [RAM_LAT:0]            r_poob;

  logic [NUM_REQ-1:0]          w_elig;
  logic                        w_found;
  logic [IDW-1:0]              w_win;
  logic [IDW-1:0]              w_ptr_nxt;
  logic [9:0]                  w_x;
  logic [9:0]                  w_y;
  logic                        w_oob;
  logic [19:0]                 w_addr;
  logic [NUM_REQ-1:0]          w_gnt_1h;
  logic [NUM_REQ-1:0]          w_rsp_1h;

  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_elig  = bus.req & ~r_pending;
    w_found = 1'b0;
    w_win   = '0;
    if (PLAYER_PRIO && w_elig[0]) begin
      w_found = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(v_idx);
      end
    end

    w_x    = bus.req_x[10*int'(w_win) +: 10];
    w_y    = bus.req_y[10*int'(w_win) +: 10];
    w_oob  = ({22'd0, w_x} >= 32'(MAP_W)) || ({22'd0, w_y} >= 32'(MAP_H));
    w_addr = 20'(w_y) * W_MAP_W + 20'(w_x);

    w_gnt_1h = w_found ? (NUM_REQ'(1) << w_win) : '0;
    w_rsp_1h = r_pv[RAM_LAT] ? (NUM_REQ'(1) << r_pid[RAM_LAT]) : '0;

    // a player grant under priority mode leaves the rotation untouched
    w_ptr_nxt = r_ptr;
    if (w_found && !(PLAYER_PRIO && w_win == '0)) begin
      w_ptr_nxt = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + IDW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!RST_N) begin
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_block <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_pv        <= '0;
      r_pid       <= '0;
      r_poob      <= '0;
    end else begin
      r_gnt    <= w_gnt_1h;
      r_mem_en <= w_found && !w_oob;
      if (w_found) begin
        r_mem_addr <= w_oob ? 20'd0 : w_addr;
      end
      r_ptr  <= w_ptr_nxt;
      r_pv   <= {r_pv[RAM_LAT-1:0], w_found};
      r_pid  <= {r_pid[RAM_LAT-1:0], w_win};
      r_poob <= {r_poob[RAM_LAT-1:0], w_oob};
      r_rsp_valid <= w_rsp_1h;
      if (r_pv[RAM_LAT]) begin
        r_rsp_block <= r_poob[RAM_LAT] | bus.mem_dout;
      end
      r_pending <= (r_pending & ~w_rsp_1h) | w_gnt_1h;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_block = r_rsp_block;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_addr  = r_mem_addr;
endmodule
